// File: rtl/demux14_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux14_stream_pkg
// Purpose  : Shared constants and channel-select encoding for the 1:4 demux
// Revision : 1.0 - initial release
// ============================================================================
package demux14_stream_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int DEF_W  = 8;
    localparam int DEF_CW = 16;

    // Same select encoding as the 4:1 byte mux
    typedef enum logic [SEL_W-1:0] {
        CH0 = 2'd0,
        CH1 = 2'd1,
        CH2 = 2'd2,
        CH3 = 2'd3
    } ch_e;

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_slot
// Purpose  : One-entry holding register with valid/ready drain and wrap counter
// Revision : 1.0 - initial release
// ============================================================================
module demux_slot
    import demux14_stream_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_accept,
    input  logic          i_ready,
    input  logic [W-1:0]  i_d,
    output logic          o_full,
    output logic [W-1:0]  o_data,
    output logic [CW-1:0] o_cnt
);

    logic          r_full;
    logic [W-1:0]  r_data;
    logic [CW-1:0] r_cnt;
    logic          w_drain;

    assign w_drain = r_full & i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            // An accept in the same cycle as a drain refills the slot
            if (i_accept) begin
                r_data <= i_d;
                r_full <= 1'b1;
            end else if (w_drain) begin
                r_full <= 1'b0;
            end
            if (w_drain) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;
    assign o_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/demux14_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux14_stream
// Purpose  : Registered 1-to-4 stream demultiplexer with per-channel handshake
// Revision : 1.0 - initial release
// ============================================================================
module demux14_stream
    import demux14_stream_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = DEF_CW
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [W-1:0]         i_d,
    input  logic [SEL_W-1:0]     i_sel,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [W-1:0]         o_y_0,
    output logic [W-1:0]         o_y_1,
    output logic [W-1:0]         o_y_2,
    output logic [W-1:0]         o_y_3,
    output logic [NUM_CH-1:0]    o_valid,
    input  logic [NUM_CH-1:0]    i_ready,
    output logic [NUM_CH*CW-1:0] o_cnt
);

    logic [NUM_CH-1:0] w_full;
    logic [W-1:0]      w_data [NUM_CH];
    ch_e               w_sel;
    logic              w_accept;

    assign w_sel = ch_e'(i_sel);

    // Only the addressed channel gates the input: head-of-line blocking is intended
    assign o_ready  = ~w_full[w_sel] | i_ready[w_sel];
    assign w_accept = i_valid & o_ready;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
            demux_slot #(
                .W  (W),
                .CW (CW)
            ) u_slot (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_accept (w_accept & (i_sel == SEL_W'(k))),
                .i_ready  (i_ready[k]),
                .i_d      (i_d),
                .o_full   (w_full[k]),
                .o_data   (w_data[k]),
                .o_cnt    (o_cnt[k*CW +: CW])
            );
        end
    endgenerate

    assign o_valid = w_full;
    assign o_y_0   = w_data[0];
    assign o_y_1   = w_data[1];
    assign o_y_2   = w_data[2];
    assign o_y_3   = w_data[3];

endmodule
`default_nettype wire

// File: doc/demux14_stream.md
Name: demux14_stream

Overview:
- Registered 1-to-4 demultiplexer: the distribution counterpart of the team's 4:1 byte mux.
- Routes one input byte stream to one of four output channels, chosen per word by a 2-bit select.
- Each output channel has a one-entry holding register and a valid/ready handshake, so each consumer can stall independently.
- Sits between a single producer (e.g. UART RX or ALU result bus) and four independent consumers.

Parameters:
- W, 8, data width of the input and of each output.
- CW, 16, width of each per-channel delivered-word counter.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_d  in  W  input data word.
- i_sel  in  2  destination channel for i_d (0..3).
- i_valid  in  1  input word present.
- o_ready  out  1  block can accept the word addressed by i_sel this cycle.
- o_y_0, o_y_1, o_y_2, o_y_3  out  W  channel data, taken from the holding registers.
- o_valid  out  4  bit k set = channel k holds a word.
- i_ready  in  4  bit k set = consumer k accepts this cycle.
- o_cnt  out  4*CW  per-channel delivered-word counters; channel k occupies bits [k*CW +: CW].

Behaviour:
- State per channel k: full[k] (1 bit), data[k] (W bits), cnt[k] (CW bits).
- Output mapping: o_valid[k] = full[k]; o_y_k = data[k]; o_cnt slice k = cnt[k].
- Reset (i_rst_n low, asynchronous): all full = 0, all data = 0, all cnt = 0.
  - During reset o_valid = 4'b0000, all o_y_k = 0, all o_cnt = 0.
  - o_ready = 1 during reset, because it follows combinationally from full = 0.
- Reset asserted mid-operation discards all buffered words immediately; no output handshake completes while reset is low.
- Ready: o_ready = ~full[i_sel] | i_ready[i_sel].
  - Combinational from i_sel, the full flags and i_ready. This is the only combinational input-to-output path.
  - o_ready does not depend on i_valid.
- Accept: i_valid & o_ready. On the next edge, data[i_sel] <= i_d and full[i_sel] <= 1.
- Drain on channel k: full[k] & i_ready[k]. On the next edge:
  - full[k] <= 0, unless the same cycle also accepts into k;
  - cnt[k] <= cnt[k] + 1, wrapping modulo 2^CW (all ones + 1 -> 0, no saturation, no flag).
- Simultaneous accept and drain on the same channel: data is replaced, full stays 1, cnt increments. This gives full throughput of one word per cycle per channel.
- Drains on different channels are independent; all four may drain in the same cycle.
- Only one accept is possible per cycle.
- Latency: a word accepted at edge N is visible on o_y_k with o_valid[k] = 1 after edge N. It can drain in that same cycle, i.e. one-cycle latency.
- Stall stability: while o_valid[k] = 1 and i_ready[k] = 0, o_y_k holds constant.
- A full channel never drops or overwrites data unless it drains in the same cycle.
- Upstream obligation: hold i_d and i_sel stable while i_valid = 1 and o_ready = 0.
  - If i_sel changes anyway, readiness is re-evaluated for the new target.
  - No error is flagged.
- Head-of-line blocking: a stalled target blocks the input even when other channels are empty. This is intended; there is no reordering.
- No state machine beyond the per-channel full flags; no other registers.

Decomposition:
- Shared package:
  - NUM_CH = 4 and SEL_W = 2;
  - default W and CW;
  - a channel-index enumeration CH0..CH3 shared with the 4:1 mux for select encoding.
- One sub-module, demux_slot: a single holding register (full flag, data register, wrap counter) with accept/drain inputs. It is instantiated four times.
- The top level holds only the select decode and the o_ready mux.

Test Plan:
- Reset check: apply i_rst_n = 0 with random inputs -> o_valid = 0000, all o_y = 0x00, all o_cnt = 0, o_ready = 1. Release reset -> the state persists until the first accept.
- Basic routing: all i_ready = 1; send 0xA0, 0xA1, 0xA2, 0xA3 with i_sel = 0, 1, 2, 3 on consecutive cycles -> each value appears on o_y_k with o_valid[k] one cycle after its accept. o_cnt ends at 1,1,1,1; o_ready stays 1 throughout.
- Backpressure: i_ready[2] = 0; send 0x55 to channel 2, then 0x66 to channel 2.
  - The first word is accepted and o_valid[2] = 1.
  - o_ready = 0 while 0x66 is presented, and o_y_2 stays 0x55.
  - Raise i_ready[2] -> 0x55 drains and 0x66 is accepted the same cycle; o_y_2 = 0x66 on the next cycle; cnt2 = 1.
- Head-of-line blocking: hold channel 1 full with i_ready[1] = 0 and present a word with i_sel = 1 -> o_ready = 0. Switch i_sel to 3 -> o_ready = 1 and the word lands in channel 3.
- Throughput: i_ready[0] = 1; stream 0x00..0xFF back-to-back to channel 0 -> 256 accepts in 256 cycles, o_y_0 sequence matches, cnt0 = 256.
- Counter wrap and async reset:
  - With CW = 4, deliver 17 words on channel 3 -> cnt3 = 1.
  - Assert i_rst_n between clock edges while channels 0 and 2 are full -> o_valid clears immediately, without waiting for a clock edge.
